// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
`timescale 1ns/1ps
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX  = 4'd9;
    localparam digit_t BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add with decimal correction and invalid-digit detection.
`timescale 1ns/1ps
module bcd_digit_add
    import bcd_pkg::*;
(
    input  digit_t a,
    input  digit_t b,
    input  logic   cin,
    output digit_t s,
    output logic   cout,
    output logic   invalid
);

    logic [4:0] t;

    always_comb begin
        t       = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        s       = t[3:0];
        cout    = 1'b0;
        // Adding 6 modulo 16 skips the six non-decimal codes.
        if (t > {1'b0, BCD_MAX}) begin
            s    = t[3:0] + BCD_CORR;
            cout = 1'b1;
        end
        invalid = (a > BCD_MAX) || (b > BCD_MAX);
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial NDIG-digit BCD adder, LSD first, one digit per clock.
// Optional subtract mode (A-B by nines complement) under BCD_SERIAL_ADDER_SUB_EN.
//
// state | meaning
// IDLE  | waiting for start after reset
// ADD   | one digit processed per clock, index 0..NDIG-1
// DONE  | result valid and held; start accepted as in IDLE
`timescale 1ns/1ps
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef BCD_SERIAL_ADDER_SUB_EN
    input  logic              sub,
`endif
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] sum,
    output logic              cout,
    output logic              err
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    state_t            state_q, state_d;
    logic [4*NDIG-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              carry_q, carry_d, cout_q, cout_d, err_q, err_d;
    logic              sub_q, sub_d;

    digit_t a_dig, b_dig, b_eff, s_dig;
    logic   co_dig, inv_dig, err_dig, init_carry;

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        b_eff = sub_q ? (BCD_MAX - b_dig) : b_dig;
        // Validity is judged on the original B digit, not its complement.
        err_dig = inv_dig || (b_dig > BCD_MAX);
    end

    bcd_digit_add u_digit (
        .a       (a_dig),
        .b       (b_eff),
        .cin     (carry_q),
        .s       (s_dig),
        .cout    (co_dig),
        .invalid (inv_dig)
    );

`ifdef BCD_SERIAL_ADDER_SUB_EN
    assign init_carry = sub;
`else
    assign init_carry = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        sub_d   = sub_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ADD;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = init_carry;
                    sub_d   = init_carry;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ADD: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (idx_q == IW'(i)) sum_d[4*i +: 4] = s_dig;
                end
                carry_d = co_dig;
                err_d   = err_q || err_dig;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = co_dig;
                    if (err_d) begin
                        sum_d  = '0;
                        cout_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            sub_q   <= sub_d;
        end
    end

    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder with NDIG=4.
`timescale 1ns/1ps
module tb_bcd_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, cout, err;
    logic [15:0] sum;
`ifdef BCD_SERIAL_ADDER_SUB_EN
    logic        sub = 1'b0;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.NDIG(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef BCD_SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for done; busy cycles must equal NDIG.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv);
        int nb;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        nb = 0;
        while (busy && nb < 20) begin
            nb++;
            tick();
        end
        chk({tag, "_busy_cycles"}, nb, 4);
        chk({tag, "_done"}, done, 1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        run_op("op1234", 16'h1234, 16'h5678);
        chk("op1234_sum", sum, 16'h6912);
        chk("op1234_cout", cout, 0);
        chk("op1234_err", err, 0);

        run_op("wrap", 16'h9999, 16'h0001);
        chk("wrap_sum", sum, 16'h0000);
        chk("wrap_cout", cout, 1);

        run_op("nine", 16'h0009, 16'h0009);
        chk("nine_sum", sum, 16'h0018);
        chk("nine_cout", cout, 0);

        run_op("bad", 16'h00A0, 16'h0001);
        chk("bad_err", err, 1);
        chk("bad_sum", sum, 16'h0000);
        chk("bad_cout", cout, 0);

        run_op("clr", 16'h0001, 16'h0001);
        chk("clr_err", err, 0);
        chk("clr_sum", sum, 16'h0002);

        // start held through ADD while operands change underneath
        a = 16'h1111;
        b = 16'h2222;
        start = 1'b1;
        tick();
        chk("hold_busy", busy, 1);
        tick();
        a = 16'h9999;
        b = 16'h9999;
        tick();
        tick();
        start = 1'b0;
        tick();
        chk("hold_done", done, 1);
        chk("hold_sum", sum, 16'h3333);
        chk("hold_cout", cout, 0);

        // back-to-back start from DONE
        a = 16'h0002;
        b = 16'h0003;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_done_drop", done, 0);
        chk("b2b_busy", busy, 1);
        tick();
        tick();
        tick();
        tick();
        chk("b2b_done", done, 1);
        chk("b2b_sum", sum, 16'h0005);

        // reset in the middle of ADD
        a = 16'h5555;
        b = 16'h5555;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_sum", sum, 16'h0000);
        chk("mrst_cout", cout, 0);
        chk("mrst_err", err, 0);
        rst = 1'b0;
        tick();
        run_op("post", 16'h0004, 16'h0005);
        chk("post_sum", sum, 16'h0009);
        chk("post_cout", cout, 0);

`ifdef BCD_SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op("sub_pos", 16'h0100, 16'h0001);
        chk("sub_pos_sum", sum, 16'h0099);
        chk("sub_pos_cout", cout, 1);
        run_op("sub_neg", 16'h0001, 16'h0002);
        chk("sub_neg_sum", sum, 16'h9999);
        chk("sub_neg_cout", cout, 0);
        sub = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Parametrised multi-digit BCD adder; successor to the single-digit BCD sum block.
- Adds two NDIG-digit packed BCD operands digit-serially, least-significant digit first, one digit per clock.
- Produces an NDIG-digit BCD sum, a decimal carry-out and an invalid-digit error flag.
- Sits between operand registers and display/accumulator logic in the lab datapath.

Parameters:
- NDIG, 4, number of BCD digits per operand (>=1); operand/sum width is 4*NDIG bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request new operation; sampled only in IDLE or DONE.
- a  input  4*NDIG  operand A, packed BCD; digit i at bits [4i+3:4i].
- b  input  4*NDIG  operand B, same packing.
- busy  output  1  high while in ADD.
- done  output  1  high while in DONE; result valid.
- sum  output  4*NDIG  BCD result, same packing.
- cout  output  1  decimal carry out of the most-significant digit.
- err  output  1  an operand digit was >9 in the last operation.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset, applied at any time including mid-operation: state=IDLE; busy=0, done=0, sum=0, cout=0, err=0. Internal digit index and carry are cleared.
- States: IDLE, ADD, DONE.
- IDLE or DONE, start=1 at edge E:
  - a and b are latched into internal registers.
  - carry=0, index=0, err=0, sum=0, cout=0.
  - Next state is ADD; done drops after E.
- ADD, edge E+1+i for i=0..NDIG-1:
  - t = A[i] + B[i] + carry, 5-bit.
  - If t>9: digit = (t+6)[3:0] and carry=1; otherwise digit = t[3:0] and carry=0.
  - The digit is written to sum[i] and index increments.
  - If A[i]>9 or B[i]>9, the err flag is set (sticky until the next start).
- At the edge that writes digit NDIG-1 (E+NDIG), state becomes DONE and cout=carry.
  - If err=1, sum and cout are forced to 0 at that same edge.
- Latency: done=1 is visible NDIG cycles after the accepting edge. Throughput is one operation per NDIG+1 cycles with back-to-back starts.
- DONE: done=1; sum, cout and err hold until start or rst.
  - start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation.
- start is ignored while in ADD; latched operands do not change mid-operation.
- Input changes on a and b after acceptance have no effect.
- Wrap-around: an all-9s sum with a carry produces sum=0, cout=1.
- NDIG=1: ADD lasts one cycle.

Optional Feature:
- Macro: BCD_SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), latched with start.
  - When sub=1, the block computes A-B: each B digit is replaced by its nines complement (9-B[i]) and the initial carry is 1.
  - cout=1 means no borrow (A>=B). cout=0 means the result is negative and sum holds its ten's complement.
  - The err check is applied to the original B digit, before complementing.
- Not defined: the sub port does not exist and the block only adds.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE, ADD, DONE).
  - constants BCD_MAX=9 and BCD_CORR=6.
  - digit type (4-bit).
- Sub-module bcd_digit_add, combinational:
  - inputs: digit a, digit b, cin.
  - outputs: digit s, cout, invalid.
  - One instance is used in the serial loop.
- Top level holds the FSM, index counter, carry flop, operand/sum registers and the err flag.

Test Plan:
- NDIG=4, a=0x1234, b=0x5678, pulse start -> busy for 4 cycles; then done=1, sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001 -> sum=0x0000, cout=1 (full wrap with carry ripple). a=0x0009, b=0x0009 -> sum=0x0018, cout=0.
- a=0x00A0, b=0x0001 -> done=1, err=1, sum=0x0000, cout=0. The next valid op (0x0001+0x0001) clears err and gives sum=0x0002.
- start held high during ADD, with a and b changed mid-op -> the result reflects the originally latched operands. start high in DONE -> new op begins next cycle and done drops.
- Assert rst during ADD (cycle 2) -> next cycle busy=0, done=0, sum=0, cout=0, err=0. A following start runs normally.
- With BCD_SERIAL_ADDER_SUB_EN:
  - sub=1, a=0x0100, b=0x0001 -> sum=0x0099, cout=1.
  - sub=1, a=0x0001, b=0x0002 -> sum=0x9999, cout=0.
